apb_wait_slave: RTL and testbench

APB completer that terminates the APB side of the AHB-to-APB bridge. Provides a 16-word register bank with programmable wait-state insertion, a read-only completed-transfer counter and PSLVERR on bad accesses. Serves as the bridge's downstream load in block- and system-level benches, and drives every Pready/Pslverr path the bridge must forward back to AHB.

---
 rtl/apb_wait_slave.sv | 107 ++++++++++
 tb/tb_apb_wait_slave.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_wait_slave.sv
// APB completer with a 16-word register bank, programmable wait states,
// a read-only completed-transfer counter and PSLVERR on bad accesses.
module apb_wait_slave #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter logic [3:0]  WAIT_DEFAULT = 4'd2
) (
  input  logic        Pclk,
  input  logic        Preset,
  input  logic        Psel,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr
);

  localparam logic [3:0] IDX_XFER_CNT = 4'd14;
  localparam logic [3:0] IDX_WAIT_CFG = 4'd15;

  // The bus SETUP cycle is the cycle spent in S_IDLE seeing Psel && !Penable;
  // leaving it straight into S_ACCESS yields the W+2 cycle transfer.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [31:0] r_regs [0:13];
  logic [31:0] r_xfer_cnt;
  logic [3:0]  r_wait;

  logic        w_in_range;
  logic [3:0]  w_idx;
  logic        w_err;
  logic        w_pready;
  logic [31:0] w_rd_mux;

  assign w_in_range = (Paddr[31:6] == BASE_ADDR[31:6]);
  assign w_idx      = Paddr[5:2];
  assign w_err      = !w_in_range || (Pwrite && (w_idx == IDX_XFER_CNT));

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        // Penable without a preceding setup phase is ignored here.
        if (Psel && !Penable) begin
          w_state_nxt = S_ACCESS;
          w_cnt_nxt   = r_wait;
        end
      end
      S_ACCESS: begin
        if (!Psel) begin
          w_state_nxt = S_IDLE;
        end else if (Penable) begin
          if (r_cnt != 4'd0) w_cnt_nxt = r_cnt - 4'd1;
          else               w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_pready = !Preset && (r_state == S_ACCESS) && (r_cnt == 4'd0) && Psel && Penable;

    w_rd_mux = 32'd0;
    if (w_idx == IDX_XFER_CNT)      w_rd_mux = r_xfer_cnt;
    else if (w_idx == IDX_WAIT_CFG) w_rd_mux = {28'd0, r_wait};
    else                            w_rd_mux = r_regs[w_idx];

    Pready  = w_pready;
    Pslverr = w_pready && w_err;
    Prdata  = (w_pready && !Pwrite && !w_err) ? w_rd_mux : 32'd0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Pclk) begin
    if (Preset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_xfer_cnt <= 32'd0;
      r_wait     <= WAIT_DEFAULT;
      // NOTE: the bank is small and its reset value is architecturally
      // visible, so it is cleared like ordinary flops rather than left as RAM.
      for (int i = 0; i < 14; i++) r_regs[i] <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_pready) begin
        r_xfer_cnt <= r_xfer_cnt + 32'd1;
        if (Pwrite && !w_err) begin
          if (w_idx == IDX_WAIT_CFG) r_wait         <= Pwdata[3:0];
          else                       r_regs[w_idx]  <= Pwdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_wait_slave.sv
// Randomized scoreboard bench for apb_wait_slave: the driver predicts each
// response from a register-map model; a monitor checks every Pready cycle.
module tb_apb_wait_slave;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        Pclk = 1'b0;
  logic        Preset, Psel, Penable, Pwrite;
  logic [31:0] Paddr, Pwdata, Prdata;
  logic        Pready, Pslverr;

  apb_wait_slave #(.BASE_ADDR(BASE), .WAIT_DEFAULT(4'd2)) dut (
    .Pclk(Pclk), .Preset(Preset), .Psel(Psel), .Penable(Penable),
    .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
    .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr)
  );

  always #5 Pclk = ~Pclk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  // Reference model: plain register map contents.
  logic [31:0] m_regs [16];
  logic [3:0]  m_wait;
  logic [31:0] m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
    m_wait = 4'd2;
    m_cnt  = 32'd0;
  endtask

  // Predicts one completed transfer, updates the model, returns latency.
  task automatic predict(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input string name, output int lat);
    exp_t e;
    logic [3:0] idx;
    logic ok;
    idx = addr[5:2];
    ok  = (addr[31:6] == BASE[31:6]) && !(wr && idx == 4'd14);
    lat = int'(m_wait) + 2;
    e.name  = name;
    e.err   = !ok;
    e.rdata = 32'd0;
    if (!wr && ok) begin
      if (idx == 4'd14)      e.rdata = m_cnt;
      else if (idx == 4'd15) e.rdata = {28'd0, m_wait};
      else                   e.rdata = m_regs[idx];
    end
    if (wr && ok) begin
      if (idx == 4'd15) m_wait = data[3:0];
      else              m_regs[idx] = data;
    end
    m_cnt = m_cnt + 32'd1;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Pclk); #1;
      Psel = 1'b0; Penable = 1'b0;
    end
  endtask

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input string name);
    int lat;
    int cyc;
    predict(wr, addr, data, name, lat);
    @(posedge Pclk); #1;
    Psel = 1'b1; Penable = 1'b0; Pwrite = wr; Paddr = addr; Pwdata = data;
    @(posedge Pclk); #1;
    Penable = 1'b1;
    cyc = 1;
    do begin
      @(negedge Pclk);
      cyc++;
    end while (!Pready && cyc < 40);
    check({name, " latency"}, cyc, lat);
  endtask

  // Drops Psel after n access cycles; no response may appear.
  task automatic xfer_abort(input logic [31:0] addr, input logic [31:0] data, input int n);
    @(posedge Pclk); #1;
    Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddr = addr; Pwdata = data;
    @(posedge Pclk); #1;
    Penable = 1'b1;
    repeat (n) begin
      @(negedge Pclk);
      check("abort no pready", {31'd0, Pready}, 32'd0);
      @(posedge Pclk); #1;
    end
    Psel = 1'b0; Penable = 1'b0;
    @(negedge Pclk);
    check("abort idle pready", {31'd0, Pready}, 32'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT completes a transfer.
  always @(negedge Pclk) begin
    if (Preset !== 1'b1) begin
      if (Pready === 1'b1) begin
        if (!(Psel && Penable))
          check("pready outside access", {30'd0, Psel, Penable}, 32'd3);
        if (sb_q.size() == 0) begin
          check("unexpected pready", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check({e.name, " pslverr"}, {31'd0, Pslverr}, {31'd0, e.err});
          check({e.name, " prdata"}, Prdata, e.rdata);
        end
      end else if (Pslverr !== 1'b0 || Prdata !== 32'd0) begin
        check("outputs idle", {31'd0, Pslverr} | Prdata, 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic        w;
    int          lat;
    Preset = 1'b1; Psel = 1'b0; Penable = 1'b0; Pwrite = 1'b0;
    Paddr = 32'd0; Pwdata = 32'd0;
    model_reset();
    repeat (3) @(posedge Pclk);
    @(negedge Pclk);
    check("reset pready", {31'd0, Pready}, 32'd0);
    check("reset pslverr", {31'd0, Pslverr}, 32'd0);
    check("reset prdata", Prdata, 32'd0);
    @(posedge Pclk); #1;
    Preset = 1'b0;

    xfer(1'b0, BASE + 32'h3C, 32'd0, "rd wait_cfg rst");
    xfer(1'b0, BASE + 32'h38, 32'd0, "rd xfer_cnt 1");

    xfer(1'b1, BASE + 32'h3C, 32'h0, "wr wait 0");
    xfer(1'b1, BASE + 32'h0C, 32'hDEAD_BEEF, "wr idx3");
    xfer(1'b0, BASE + 32'h0C, 32'd0, "rd idx3");

    xfer(1'b1, BASE + 32'h3C, 32'hF, "wr wait F");
    xfer(1'b0, BASE + 32'h00, 32'd0, "rd idx0 W15");
    xfer(1'b1, BASE + 32'h3C, 32'h1234_5678, "wr wait mask");
    xfer(1'b0, BASE + 32'h3C, 32'd0, "rd wait mask");

    xfer(1'b1, BASE + 32'h40, 32'hAAAA_5555, "wr out of range");
    xfer(1'b1, BASE + 32'h38, 32'h5555_AAAA, "wr xfer_cnt");
    xfer(1'b0, BASE + 32'h80, 32'd0, "rd out of range");
    xfer(1'b0, BASE + 32'h38, 32'd0, "rd xfer_cnt err");

    idle(1);
    xfer(1'b1, BASE + 32'h3C, 32'h3, "wr wait 3");
    xfer_abort(BASE + 32'h14, 32'hCAFE_F00D, 2);
    xfer(1'b0, BASE + 32'h14, 32'd0, "rd idx5 after abort");
    xfer(1'b0, BASE + 32'h38, 32'd0, "rd xfer_cnt abort");

    idle(1);
    force dut.r_xfer_cnt = 32'hFFFF_FFFF;
    @(negedge Pclk);
    release dut.r_xfer_cnt;
    m_cnt = 32'hFFFF_FFFF;
    xfer(1'b1, BASE + 32'h04, 32'h0BAD_F00D, "wr wrap");
    xfer(1'b0, BASE + 32'h38, 32'd0, "rd xfer_cnt wrap");

    // Penable without setup phase must be ignored.
    @(posedge Pclk); #1;
    Psel = 1'b1; Penable = 1'b1; Pwrite = 1'b0; Paddr = BASE;
    repeat (3) begin
      @(negedge Pclk);
      check("violation pready", {31'd0, Pready}, 32'd0);
    end
    idle(1);

    for (int i = 0; i < 80; i++) begin
      w = 1'($urandom_range(0, 1));
      a = BASE + {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) a = a + 32'h40 * $urandom_range(1, 1000);
      d = $urandom;
      if (a[5:2] == 4'd15 && w) d[3:0] = 4'($urandom_range(0, 4));
      xfer(w, a, d, $sformatf("rand %0d", i));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end

    // Reset during the Pready-eligible ACCESS cycle of a W=0 write.
    xfer(1'b1, BASE + 32'h3C, 32'h0, "wr wait 0 b");
    @(posedge Pclk); #1;
    Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddr = BASE + 32'h1C; Pwdata = 32'h7777_7777;
    @(posedge Pclk); #1;
    Penable = 1'b1; Preset = 1'b1;
    @(negedge Pclk);
    check("rst mid pready", {31'd0, Pready}, 32'd0);
    @(posedge Pclk); #1;
    Preset = 1'b0; Psel = 1'b0; Penable = 1'b0;
    model_reset();
    @(negedge Pclk);
    check("post rst outputs", {30'd0, Pready, Pslverr} | Prdata, 32'd0);
    xfer(1'b0, BASE + 32'h1C, 32'd0, "rd idx7 after rst");
    xfer(1'b0, BASE + 32'h3C, 32'd0, "rd wait after rst");
    idle(2);

    check("scoreboard drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
